// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch front-end: FSM states, queue entry layout, queue depth.
package ifetch_pkg;

  localparam int unsigned QDEPTH   = 2;
  localparam int unsigned EntryPcW = 32;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFault
  } ifetch_state_e;

  typedef struct packed {
    logic [31:0]         instr;
    logic [EntryPcW-1:0] pc;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Two-entry flushable FIFO holding fetched {instr, pc} pairs; head fields read as zero when empty.
module ifetch_queue
  import ifetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [31:0]         push_instr_i,
  input  logic [EntryPcW-1:0] push_pc_i,
  output logic [31:0]         head_instr_o,
  output logic [EntryPcW-1:0] head_pc_o,
  output logic [1:0]          count_o
);

  ifetch_entry_t ent_q [QDEPTH];
  ifetch_entry_t ent_d [QDEPTH];
  logic [1:0]    count_q, count_d;
  logic [1:0]    level;
  logic          do_pop, do_push;
  ifetch_entry_t new_ent;

  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    new_ent = '{instr: push_instr_i, pc: push_pc_i};
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q < 2'(QDEPTH)) || do_pop);
    level   = count_q - {1'b0, do_pop};
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      // Shift toward the head on pop, then write the new entry at the post-pop tail.
      if (do_pop) begin
        ent_d[0] = ent_q[1];
      end
      if (do_push) begin
        ent_d[level[0]] = new_ent;
      end
      count_d = level + {1'b0, do_push};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      for (int i = 0; i < QDEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  assign count_o      = count_q;
  assign head_instr_o = (count_q != 2'd0) ? ent_q[0].instr : 32'd0;
  assign head_pc_o    = (count_q != 2'd0) ? ent_q[0].pc : '0;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: PC/FSM, sequential fetch, redirects, 2-entry decode queue.
// Optional bounds fault on fetches beyond MEM_WORDS when IFETCH_BOUNDS_CHECK_EN is defined.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              fetch_fault
);

`ifdef IFETCH_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  ifetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                fault_q, fault_d;
  logic                push, flush, pop, oob;
  logic [1:0]          q_count;
  logic [EntryPcW-1:0] head_pc;
  logic [ADDR_W-1:0]   target_pc;
  logic                unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign imem_addr = pc_q >> 2;
  assign oob       = BoundsEn && (imem_addr >= ADDR_W'(MEM_WORDS));
  assign if_valid  = (q_count != 2'd0) && !redirect_valid;
  assign pop       = if_valid && if_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        if (redirect_valid) begin
          pc_d = target_pc;
        end
      end
      StRun: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = target_pc;
        end else if ((q_count < 2'(QDEPTH)) || pop) begin
          if (oob) begin
            state_d = StFault;
            fault_d = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = pc_q + ADDR_W'(4);
          end
        end
      end
      // Only the queue drains here; redirects and fetches are ignored until reset.
      StFault: ;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= ADDR_W'(RESET_PC);
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  ifetch_queue u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .push_i       (push),
    .pop_i        (pop),
    .push_instr_i (imem_data),
    .push_pc_i    (EntryPcW'(pc_q)),
    .head_instr_o (if_instr),
    .head_pc_o    (head_pc),
    .count_o      (q_count)
  );

  assign if_pc       = ADDR_W'(head_pc);
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized self-checking bench for ifetch_unit against a queue-based transaction model.
module tb_ifetch_unit;

  localparam int unsigned MemWords = 256;
`ifdef IFETCH_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        if_valid, if_ready = 1'b0;
  logic [31:0] if_instr, if_pc;
  logic        fetch_fault;

  logic [31:0] mem [MemWords];
  assign imem_data = mem[imem_addr[7:0]];

  ifetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (MemWords),
    .ADDR_W    (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_boot, m_fault;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = 32'd0;
    m_boot  = 1'b1;
    m_fault = 1'b0;
  endtask

  // One clock: drive after negedge, check, then advance the model across the posedge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit   vld;
    ent_t e;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    if_ready       = rdy;
    #1;
    vld = (mq.size() != 0) && !redir;
    check_eq("if_valid", if_valid, vld);
    check_eq("if_pc", if_pc, (mq.size() != 0) ? mq[0].pc : 32'd0);
    check_eq("if_instr", if_instr, (mq.size() != 0) ? mq[0].instr : 32'd0);
    check_eq("imem_addr", imem_addr, m_pc >> 2);
    check_eq("fetch_fault", fetch_fault, m_fault);
    @(posedge clk);
    if (m_boot) begin
      m_boot = 1'b0;
      if (redir) m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (vld && rdy) void'(mq.pop_front());
      if (!m_fault) begin
        if (redir) begin
          mq.delete();
          m_pc = {rpc[31:2], 2'b00};
        end else if (mq.size() < 2) begin
          if (BoundsEn && ((m_pc >> 2) >= MemWords)) begin
            m_fault = 1'b1;
          end else begin
            e.instr = mem[(m_pc >> 2) % MemWords];
            e.pc    = m_pc;
            mq.push_back(e);
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases just after a posedge.
  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_if_valid", if_valid, 1'b0);
    check_eq("rst_if_pc", if_pc, 32'd0);
    check_eq("rst_if_instr", if_instr, 32'd0);
    check_eq("rst_fetch_fault", fetch_fault, 1'b0);
    check_eq("rst_imem_addr", imem_addr, 32'd0);
    model_reset();
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < MemWords; i++) mem[i] = $urandom;
    mem[0] = 32'h2010_FFFC;
    mem[1] = 32'h2011_0008;
    mem[2] = 32'h0211_9020;
    mem[3] = 32'h1240_FFFC;
    model_reset();

    apply_reset();
    repeat (6) step(1'b0, 32'd0, 1'b1);
    // Decode stall then release.
    repeat (5) step(1'b0, 32'd0, 1'b0);
    repeat (5) step(1'b0, 32'd0, 1'b1);
    // Redirect while the queue is full and decode is ready.
    repeat (3) step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h0000_000E, 1'b1);
    repeat (4) step(1'b0, 32'd0, 1'b1);
    // Long streaming run across the end of memory.
    step(1'b1, 32'd0, 1'b1);
    repeat (300) step(1'b0, 32'd0, 1'b1);
    // Last in-range word, then the following word; a later redirect.
    step(1'b1, 32'h0000_03FC, 1'b1);
    repeat (4) step(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'h0000_0040, 1'b1);
    repeat (3) step(1'b0, 32'd0, 1'b1);
    // Redirect during boot, fill the queue, then reset with two entries pending.
    apply_reset();
    step(1'b1, 32'h0000_0080, 1'b0);
    repeat (4) step(1'b0, 32'd0, 1'b0);
    apply_reset();
    repeat (4) step(1'b0, 32'd0, 1'b1);
    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        apply_reset();
      end else begin
        step($urandom_range(0, 7) == 0, 32'($urandom_range(0, 32'h3FF)),
             $urandom_range(0, 3) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
